// File: rtl/mme_apb_cfg_slave.sv
// APB completer for the MME programming model: config registers,
// command/start pulse and sticky done/busy status.
module mme_apb_cfg_slave #(
    parameter logic [31:0] IP_VERSION  = 32'h0001_0000,
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [31:0]       mat_width_o,
    output logic [31:0]       mat_a_addr_o,
    output logic [31:0]       mat_b_addr_o,
    output logic [31:0]       mat_c_addr_o,
    output logic              start_o,
    input  logic              done_i,
    output logic              busy_o
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    localparam logic [ADDR_W-1:0] A_VER  = ADDR_W'(12'h000);
    localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(12'h100);
    localparam logic [ADDR_W-1:0] A_MA   = ADDR_W'(12'h200);
    localparam logic [ADDR_W-1:0] A_MB   = ADDR_W'(12'h204);
    localparam logic [ADDR_W-1:0] A_MC   = ADDR_W'(12'h208);
    localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(12'h20C);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(12'h210);

    logic [2:0]  cnt;
    logic        busy;
    logic        done;
    logic        access;
    logic        wr;
    logic        err;
    logic [31:0] rd;
    logic        start_ok;

    logic sel_ver, sel_cfg, sel_ma, sel_mb, sel_mc, sel_cmd, sel_stat;

    assign sel_ver  = (paddr == A_VER);
    assign sel_cfg  = (paddr == A_CFG);
    assign sel_ma   = (paddr == A_MA);
    assign sel_mb   = (paddr == A_MB);
    assign sel_mc   = (paddr == A_MC);
    assign sel_cmd  = (paddr == A_CMD);
    assign sel_stat = (paddr == A_STAT);

    // Reset is high-active here, so it also gates the handshake outputs
    assign access = psel & penable & ~rst_n;
    assign pready = access & (cnt == WS);
    assign wr     = pready & pwrite;

    always_comb begin
        rd  = '0;
        err = 1'b0;
        unique case (1'b1)
            sel_ver: begin
                rd  = IP_VERSION;
                err = pwrite;
            end
            sel_cfg: begin
                rd  = mat_width_o;
                err = pwrite & busy;
            end
            sel_ma: begin
                rd  = mat_a_addr_o;
                err = pwrite & (busy | (pwdata[1:0] != 2'b00));
            end
            sel_mb: begin
                rd  = mat_b_addr_o;
                err = pwrite & (busy | (pwdata[1:0] != 2'b00));
            end
            sel_mc: begin
                rd  = mat_c_addr_o;
                err = pwrite & (busy | (pwdata[1:0] != 2'b00));
            end
            sel_cmd: begin
                rd  = '0;
                err = pwrite & busy & pwdata[0];
            end
            sel_stat: begin
                rd  = {30'd0, busy, done};
                err = pwrite;
            end
            default: begin
                rd  = '0;
                err = 1'b1;
            end
        endcase
    end

    assign prdata   = (pready & ~pwrite) ? rd : 32'd0;
    assign pslverr  = pready & err;
    assign start_ok = wr & ~err & sel_cmd & pwdata[0];
    assign busy_o   = busy;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (!psel || pready) begin
            cnt <= '0;
        end else if (access && cnt < WS) begin
            cnt <= cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mat_width_o  <= '0;
            mat_a_addr_o <= '0;
            mat_b_addr_o <= '0;
            mat_c_addr_o <= '0;
        end else if (wr && !err) begin
            if (sel_cfg) mat_width_o  <= pwdata;
            if (sel_ma)  mat_a_addr_o <= pwdata;
            if (sel_mb)  mat_b_addr_o <= pwdata;
            if (sel_mc)  mat_c_addr_o <= pwdata;
        end
    end

    // An accepted start takes priority over a coincident done pulse
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            start_o <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_o <= start_ok;
            if (start_ok) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (done_i && busy) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mme_apb_cfg_slave.sv
// Directed bench for mme_apb_cfg_slave: vector table for register
// access plus hand sequences for start/done and mid-transfer reset.
module tb_mme_apb_cfg_slave;

    localparam logic [31:0] IPV = 32'h0001_0000;
    localparam int          WS  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [11:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] mat_width_o;
    logic [31:0] mat_a_addr_o;
    logic [31:0] mat_b_addr_o;
    logic [31:0] mat_c_addr_o;
    logic        start_o;
    logic        done_i = 1'b0;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    mme_apb_cfg_slave #(
        .IP_VERSION (IPV),
        .ADDR_W     (12),
        .WAIT_STATES(WS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .psel        (psel),
        .penable     (penable),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr),
        .mat_width_o (mat_width_o),
        .mat_a_addr_o(mat_a_addr_o),
        .mat_b_addr_o(mat_b_addr_o),
        .mat_c_addr_o(mat_c_addr_o),
        .start_o     (start_o),
        .done_i      (done_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One APB transfer; returns data, error and low-pready access cycles
    task automatic apb(input bit w, input logic [11:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic err, output int waits);
        @(posedge clk) #1;
        psel = 1'b1; penable = 1'b0;
        pwrite = w; paddr = a; pwdata = d;
        @(posedge clk) #1;
        penable = 1'b1;
        waits = 0;
        rd = '0;
        err = 1'b0;
        #1;
        while (pready !== 1'b1 && waits < 20) begin
            waits++;
            @(posedge clk) #2;
        end
        if (pready !== 1'b1) begin
            errors++;
            $display("FAIL pready_timeout: got no pready expected pready");
        end else begin
            rd  = prdata;
            err = pslverr;
        end
        @(posedge clk) #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic add(input bit w, input logic [11:0] a,
                       input logic [31:0] d, input logic [31:0] e,
                       input bit er);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d;
        v.exp_rd = e; v.exp_err = er;
        vecs.push_back(v);
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;

    initial begin
        add(0, 12'h000, 0, IPV, 0);
        add(0, 12'h100, 0, 0, 0);
        add(0, 12'h200, 0, 0, 0);
        add(0, 12'h210, 0, 0, 0);
        add(1, 12'h100, 8, 0, 0);
        add(1, 12'h200, 32'h0, 0, 0);
        add(1, 12'h204, 32'h1000, 0, 0);
        add(1, 12'h208, 32'h2000, 0, 0);
        add(0, 12'h100, 0, 8, 0);
        add(0, 12'h200, 0, 0, 0);
        add(0, 12'h204, 0, 32'h1000, 0);
        add(0, 12'h208, 0, 32'h2000, 0);
        add(1, 12'h204, 32'h1002, 0, 1);
        add(0, 12'h204, 0, 32'h1000, 0);
        add(0, 12'h3FC, 0, 0, 1);
        add(1, 12'h000, 32'h5, 0, 1);
        add(0, 12'h000, 0, IPV, 0);
        add(1, 12'h210, 32'h3, 0, 1);
        add(0, 12'h210, 0, 0, 0);
        add(1, 12'h20C, 32'h0, 0, 0);
        add(0, 12'h20C, 0, 0, 0);
        add(0, 12'h210, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", 32'(pready), 0);
        chk("rst_width", mat_width_o, 0);
        chk("rst_start", 32'(start_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst_n = 1'b0;

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, wt);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_waits", i), wt, WS);
        end
        chk("out_width", mat_width_o, 8);
        chk("out_a", mat_a_addr_o, 0);
        chk("out_b", mat_b_addr_o, 32'h1000);
        chk("out_c", mat_c_addr_o, 32'h2000);

        apb(1, 12'h20C, 1, rd, er, wt);
        chk("start_err", 32'(er), 0);
        chk("start_hi", 32'(start_o), 1);
        @(posedge clk) #1;
        chk("start_lo", 32'(start_o), 0);
        apb(0, 12'h210, 0, rd, er, wt);
        chk("stat_busy", rd, 2);
        apb(1, 12'h100, 12, rd, er, wt);
        chk("cfg_busy_err", 32'(er), 1);
        apb(0, 12'h100, 0, rd, er, wt);
        chk("cfg_kept", rd, 8);
        apb(1, 12'h20C, 1, rd, er, wt);
        chk("cmd_busy_err", 32'(er), 1);
        chk("cmd_busy_nostart", 32'(start_o), 0);

        done_i = 1'b1;
        @(posedge clk) #1;
        done_i = 1'b0;
        apb(0, 12'h210, 0, rd, er, wt);
        chk("stat_done", rd, 1);

        done_i = 1'b1;
        @(posedge clk) #1;
        done_i = 1'b0;
        apb(0, 12'h210, 0, rd, er, wt);
        chk("stat_idle_done", rd, 1);

        done_i = 1'b1;
        apb(1, 12'h20C, 1, rd, er, wt);
        done_i = 1'b0;
        chk("coinc_start", 32'(start_o), 1);
        apb(0, 12'h210, 0, rd, er, wt);
        chk("coinc_stat", rd, 2);

        @(posedge clk) #1;
        psel = 1'b1; penable = 1'b0;
        pwrite = 1'b1; paddr = 12'h100; pwdata = 32'h77;
        @(posedge clk) #1;
        penable = 1'b1;
        @(posedge clk) #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_pready", 32'(pready), 0);
        chk("mid_rst_width", mat_width_o, 0);
        chk("mid_rst_start", 32'(start_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b0;

        apb(1, 12'h208, 32'h40, rd, er, wt);
        chk("post_wr_err", 32'(er), 0);
        apb(0, 12'h208, 0, rd, er, wt);
        chk("post_rd", rd, 32'h40);
        chk("post_waits", wt, WS);
        apb(0, 12'h100, 0, rd, er, wt);
        chk("post_cfg", rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mme_apb_cfg_slave.md
Name: mme_apb_cfg_slave

Overview:
APB completer that owns the MME programming model: IP version, matrix width, A/B/C base addresses, command and status registers. It turns APB transfers into register updates and a one-cycle start pulse to the MME datapath, and collects the datapath's done pulse into a sticky status bit. It sits between the APB port of MME_TOP and the MME engine.

Parameters:
IP_VERSION, 32'h0001_0000, value returned at offset 0x000.
ADDR_W, 12, APB address width; only paddr[ADDR_W-1:0] is decoded.
WAIT_STATES, 0, number of access-phase cycles with pready low before completion (0..7).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
psel  in  1  APB select
penable  in  1  APB enable (access phase)
paddr  in  ADDR_W  APB byte address
pwrite  in  1  1 = write, 0 = read
pwdata  in  32  write data
pready  out  1  transfer completes this cycle
prdata  out  32  read data, valid when pready & !pwrite
pslverr  out  1  error response, valid when pready
mat_width_o  out  32  MAT_CFG register
mat_a_addr_o  out  32  A base address
mat_b_addr_o  out  32  B base address
mat_c_addr_o  out  32  C base address
start_o  out  1  one-cycle start pulse to engine
done_i  in  1  one-cycle completion pulse from engine
busy_o  out  1  engine running

Behaviour:
- Reset (rst_n high, async): all config registers 0, start_o 0, busy_o 0, done 0, wait counter 0. Outputs are 0 while reset is asserted.
- Register map:
  - 0x000 IP_VER: RO, returns IP_VERSION.
  - 0x100 MAT_CFG: RW, 32 bits.
  - 0x200 MAT_A_ADDR: RW.
  - 0x204 MAT_B_ADDR: RW.
  - 0x208 MAT_C_ADDR: RW.
  - 0x20C MME_CMD: WO, reads return 0.
  - 0x210 MME_STATUS: RO; bit0 done, bit1 busy, others 0.
- Handshake:
  - Setup phase: psel & !penable.
  - Access phase: psel & penable. Wait counter increments each access cycle while below WAIT_STATES.
  - pready = psel & penable & (cnt == WAIT_STATES). With WAIT_STATES=0, every transfer finishes in 2 cycles.
  - Counter clears on completion or when psel is low.
  - pready, prdata and pslverr are 0 outside the completing cycle.
- Write side effects occur only on the completing cycle (psel & penable & pready & pwrite). Register values update on the following clock edge.
- prdata is a combinational mux of the current register values during the completing cycle.
- Address registers: a write with pwdata[1:0] != 0 returns pslverr=1, and the register is unchanged.
- MME_CMD write with pwdata[0]=1 and busy=0:
  - start_o=1 for exactly the next cycle.
  - busy set, done cleared.
- MME_CMD write with pwdata[0]=0: no effect, no error.
- Writes to MAT_CFG, address registers or MME_CMD(bit0=1) while busy: pslverr=1, ignored.
- Writes to IP_VER or STATUS: pslverr=1, no effect.
- Unmapped offset (read or write): pslverr=1, prdata=0.
- done_i while busy: busy cleared, done set (sticky until next start).
- done_i while not busy: ignored.
- done_i on the same cycle as an accepted start: start wins; done_i is ignored.
- STATUS read on the same cycle as done_i: returns pre-update value; the next read sees done=1.
- psel dropped mid access (protocol violation): counter clears, no side effects.
- Reset asserted mid-transfer: pready drops immediately; all state returns to reset values.

Test Plan:
- After reset, read 0x000 -> prdata=IP_VERSION, pslverr=0. Read 0x100/0x200/0x210 -> 0.
- Write 0x100=8, 0x200=0x0, 0x204=0x1000, 0x208=0x2000, then read back each -> identical values. Outputs mat_* match. WAIT_STATES=3 -> pready after exactly 3 low access cycles.
- Write 0x20C=1 -> start_o high exactly 1 cycle; STATUS=0x2. Write 0x100=12 while busy -> pslverr=1, MAT_CFG stays 8. Pulse done_i -> STATUS=0x1.
- Write 0x204=0x1002 -> pslverr=1, reg unchanged. Read 0x3FC -> pslverr=1, prdata=0. Write 0x000 -> pslverr=1.
- done_i on the same cycle as the start write completion -> busy=1, done=0. done_i while idle -> STATUS unchanged.
- Assert rst_n during the access phase of a write to 0x100 -> pready=0, register=0, start_o=0. Release reset -> normal transfers resume.
